// File: rtl/param_load_ctrl_if.sv
// param_load_ctrl_if: parameter-load stream, buffer-write and bias-read
// signals for param_load_ctrl. The master modport is the side that supplies
// the stream and read requests. The slave modport is the controller.
interface param_load_ctrl_if #(
   parameter int LW_DEPTH = 256
);
   localparam int LW_AW = (LW_DEPTH > 1) ? $clog2(LW_DEPTH) : 1;

   logic              start;
   logic              in_valid;
   logic [15:0]       in_data;
   logic              in_ready;
   logic [15:0]       wr_data;
   logic              lw_wr_en;
   logic [LW_AW-1:0]  lw_addr;
   logic              cb_wr_en;
   logic [4:0]        cb_addr;
   logic              done_linear_weight;
   logic              done_conv_bias;
   logic              rd_req;
   logic              bias_r_en;
   logic              busy;
   logic              err;

   modport master (
      output start, in_valid, in_data, rd_req,
      input  in_ready, wr_data, lw_wr_en, lw_addr, cb_wr_en, cb_addr,
             done_linear_weight, done_conv_bias, bias_r_en, busy, err
   );

   modport slave (
      input  start, in_valid, in_data, rd_req,
      output in_ready, wr_data, lw_wr_en, lw_addr, cb_wr_en, cb_addr,
             done_linear_weight, done_conv_bias, bias_r_en, busy, err
   );
endinterface

// File: rtl/param_load_ctrl.sv
// param_load_ctrl: loads a serial 16-bit parameter stream into the
// linear-weight buffer (LW_DEPTH words) and then into the conv-bias buffer
// (CB_DEPTH words). Once both buffers are full, each rising edge of rd_req
// produces one bias read enable.
// Optional feature: define PARAM_LOAD_TIMEOUT_EN to enable the idle-stream
// timeout. If the stream stalls for TIMEOUT cycles, the controller enters ERR.
module param_load_ctrl #(
   parameter int LW_DEPTH = 256,
   parameter int CB_DEPTH = 32,
   parameter int TIMEOUT  = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   param_load_ctrl_if.slave bus
);

   localparam int               LW_AW   = (LW_DEPTH > 1) ? $clog2(LW_DEPTH) : 1;
   localparam logic [LW_AW-1:0] LW_LAST = LW_AW'(LW_DEPTH - 1);
   localparam logic [4:0]       CB_LAST = 5'(CB_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_LW,
      S_LOAD_CB,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q;
   logic [LW_AW-1:0] lw_cnt_q;
   logic [LW_AW-1:0] lw_addr_q;
   logic [4:0]       cb_cnt_q;
   logic [4:0]       cb_addr_q;
   logic [15:0]      wr_data_q;
   logic             lw_wr_en_q;
   logic             cb_wr_en_q;
   logic             done_lw_q;
   logic             done_cb_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             bias_r_en_q;
   logic             rd_req_q;

`ifdef PARAM_LOAD_TIMEOUT_EN
   localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] idle_cnt_q;
   logic            err_q;
`endif

   logic accept;
   logic rd_rise;

   // A word is taken whenever the stream is valid while loading.
   // A rise on rd_req is detected against its previous sample.
   always_comb begin
      accept  = bus.in_valid & in_ready_q;
      rd_rise = bus.rd_req & ~rd_req_q;
   end

   // Load sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lw_cnt_q    <= '0;
         lw_addr_q   <= '0;
         cb_cnt_q    <= '0;
         cb_addr_q   <= '0;
         wr_data_q   <= '0;
         lw_wr_en_q  <= 1'b0;
         cb_wr_en_q  <= 1'b0;
         done_lw_q   <= 1'b0;
         done_cb_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         bias_r_en_q <= 1'b0;
         rd_req_q    <= 1'b0;
`ifdef PARAM_LOAD_TIMEOUT_EN
         idle_cnt_q  <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         lw_wr_en_q  <= 1'b0;
         cb_wr_en_q  <= 1'b0;
         bias_r_en_q <= 1'b0;
         rd_req_q    <= bus.rd_req;

         case (state_q)
            S_LOAD_LW: begin
               if (accept) begin
                  wr_data_q  <= bus.in_data;
                  lw_wr_en_q <= 1'b1;
                  lw_addr_q  <= lw_cnt_q;
                  if (lw_cnt_q == LW_LAST) begin
                     done_lw_q <= 1'b1;
                     state_q   <= S_LOAD_CB;
                  end else begin
                     lw_cnt_q <= lw_cnt_q + 1'b1;
                  end
               end
            end

            S_LOAD_CB: begin
               if (accept) begin
                  wr_data_q  <= bus.in_data;
                  cb_wr_en_q <= 1'b1;
                  cb_addr_q  <= cb_cnt_q;
                  if (cb_cnt_q == CB_LAST) begin
                     done_cb_q  <= 1'b1;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     state_q    <= S_DONE;
                  end else begin
                     cb_cnt_q <= cb_cnt_q + 1'b1;
                  end
               end
            end

            // IDLE, DONE and ERR all restart on start. Only DONE serves reads,
            // and start takes priority over a coincident rd_req rise.
            default: begin
               if (bus.start) begin
                  state_q    <= S_LOAD_LW;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  lw_cnt_q   <= '0;
                  cb_cnt_q   <= '0;
                  lw_addr_q  <= '0;
                  cb_addr_q  <= '0;
                  done_lw_q  <= 1'b0;
                  done_cb_q  <= 1'b0;
`ifdef PARAM_LOAD_TIMEOUT_EN
                  err_q      <= 1'b0;
                  idle_cnt_q <= '0;
`endif
               end else if ((state_q == S_DONE) && rd_rise) begin
                  bias_r_en_q <= 1'b1;
               end
            end
         endcase

`ifdef PARAM_LOAD_TIMEOUT_EN
         // busy_q is high exactly in the two load states, so it gates the idle count.
         if (busy_q) begin
            if (bus.in_valid) begin
               idle_cnt_q <= '0;
            end else if (idle_cnt_q == TO_LAST) begin
               state_q    <= S_ERR;
               err_q      <= 1'b1;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               idle_cnt_q <= '0;
            end else begin
               idle_cnt_q <= idle_cnt_q + 1'b1;
            end
         end
`endif
      end
   end

   assign bus.in_ready           = in_ready_q;
   assign bus.wr_data            = wr_data_q;
   assign bus.lw_wr_en           = lw_wr_en_q;
   assign bus.lw_addr            = lw_addr_q;
   assign bus.cb_wr_en           = cb_wr_en_q;
   assign bus.cb_addr            = cb_addr_q;
   assign bus.done_linear_weight = done_lw_q;
   assign bus.done_conv_bias     = done_cb_q;
   assign bus.bias_r_en          = bias_r_en_q;
   assign bus.busy               = busy_q;
`ifdef PARAM_LOAD_TIMEOUT_EN
   assign bus.err                = err_q;
`else
   assign bus.err                = 1'b0;
`endif

endmodule
